axioma_timer_prescaler: RTL

Shared synchronous prescaler for Timer/Counter 0 and Timer/Counter 1, ATmega328P compatible. A single 10-bit free-running counter produces clk/8, clk/64, clk/256 and clk/1024 taps. The block also synchronises and edge-detects the external T0/T1 clock pins. It emits one-cycle count-enable pulses tick0/tick1, which axioma_timer0 and axioma_timer1 consume as their only count enable. It owns the GTCCR register (TSM, PSRSYNC).

---
 rtl/axioma_timer_prescaler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/axioma_timer_prescaler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : axioma_timer_prescaler
// Description : Shared Timer0/Timer1 prescaler (ATmega328P compatible).
//               A 10-bit free-running counter provides the clk/8, /64, /256
//               and /1024 taps. The block emits registered one-cycle count
//               enables tick0/tick1 and owns GTCCR (TSM, PSRSYNC).
//               Optional macro AXIOMA_PRESC_EXTCLK_EN builds the T0/T1 pin
//               synchronisers and edge detectors (cs = 110/111).
// Revision    : 1.0 - initial release
// ============================================================================
module axioma_timer_prescaler #(
   parameter logic [5:0] GTCCR_ADDR  = 6'h23,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] io_addr,
   input  logic [7:0] io_data_in,
   output logic [7:0] io_data_out,
   input  logic       io_read,
   input  logic       io_write,
   input  logic [2:0] cs0,
   input  logic [2:0] cs1,
   input  logic       t0_pin,
   input  logic       t1_pin,
   output logic       tick0,
   output logic       tick1,
   output logic [9:0] debug_presc_cnt
);

   logic [9:0] r_presc_cnt;
   logic       r_tsm;
   logic       r_psrsync;
   logic       r_tick0;
   logic       r_tick1;

   logic       w_gtccr_wr;
   logic       w_gtccr_sel;
   logic       w_clr;
   logic       w_presc_en;
   logic [3:0] w_taps;
   logic [1:0] w_rise;
   logic [1:0] w_fall;
   logic       w_unused;

   assign w_gtccr_sel = (io_addr == GTCCR_ADDR);
   assign w_gtccr_wr  = io_write & w_gtccr_sel;
   assign w_clr       = w_gtccr_wr & io_data_in[0];

   // Prescaled ticks are blocked while synchronised reset is held and on the
   // edge where software clears the counter (that tick is lost).
   assign w_presc_en  = ~r_psrsync & ~w_clr;

   assign w_taps[0] = &r_presc_cnt[2:0];
   assign w_taps[1] = &r_presc_cnt[5:0];
   assign w_taps[2] = &r_presc_cnt[7:0];
   assign w_taps[3] = &r_presc_cnt[9:0];

`ifdef AXIOMA_PRESC_EXTCLK_EN
   logic [1:0] w_pin;
   assign w_pin    = {t1_pin, t0_pin};
   assign w_unused = ^io_data_in[6:1];

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_ext
      logic [SYNC_STAGES-1:0] r_sync;
      logic                   r_hist;

      // Synchronise the asynchronous pin and keep one history flop for edge detect
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
         end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin[gi]};
            r_hist <= r_sync[SYNC_STAGES-1];
         end
      end

      assign w_rise[gi] =  r_sync[SYNC_STAGES-1] & ~r_hist;
      assign w_fall[gi] = ~r_sync[SYNC_STAGES-1] &  r_hist;
   end
`else
   // External clock sources are not built: pins are ignored.
   assign w_rise   = 2'b00;
   assign w_fall   = 2'b00;
   assign w_unused = ^{io_data_in[6:1], t1_pin, t0_pin};
`endif

   // Clock-select mux shared by both timers
   function automatic logic f_tick_sel(input logic [2:0] cs, input logic [3:0] taps,
                                       input logic fall, input logic rise);
      logic v;
      case (cs)
         3'b000:  v = 1'b0;
         3'b001:  v = 1'b1;
         3'b010:  v = taps[0];
         3'b011:  v = taps[1];
         3'b100:  v = taps[2];
         3'b101:  v = taps[3];
         3'b110:  v = fall;
         default: v = rise;
      endcase
      return v;
   endfunction

   // Free-running prescaler counter, cleared by GTCCR write and held by PSRSYNC
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_presc_cnt <= 10'd0;
      end else if (w_clr || r_psrsync) begin
         r_presc_cnt <= 10'd0;
      end else begin
         r_presc_cnt <= r_presc_cnt + 10'd1;
      end
   end

   // GTCCR register: PSRSYNC can only stay set alongside TSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tsm     <= 1'b0;
         r_psrsync <= 1'b0;
      end else if (w_gtccr_wr) begin
         r_tsm     <= io_data_in[7];
         r_psrsync <= io_data_in[0] & io_data_in[7];
      end
   end

   // Registered count-enable pulses for Timer0 and Timer1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tick0 <= 1'b0;
         r_tick1 <= 1'b0;
      end else begin
         r_tick0 <= f_tick_sel(cs0, w_taps & {4{w_presc_en}}, w_fall[0], w_rise[0]);
         r_tick1 <= f_tick_sel(cs1, w_taps & {4{w_presc_en}}, w_fall[1], w_rise[1]);
      end
   end

   // Combinational GTCCR read; bit 1 always reads zero
   always_comb begin
      io_data_out = 8'h00;
      if (io_read && w_gtccr_sel) begin
         io_data_out = {r_tsm, 5'b00000, 1'b0, r_psrsync};
      end
   end

   assign tick0           = r_tick0;
   assign tick1           = r_tick1;
   assign debug_presc_cnt = r_presc_cnt;

endmodule
`default_nettype wire
